// File: rtl/rr_mux.sv
// CHANNELS:1 arbitrated mux into a single-entry output register.
// MODE 0 = round-robin from a rotating pointer, MODE 1 = fixed priority (lowest index).
module rr_mux #(
    parameter int N        = 32,
    parameter int CHANNELS = 32,
    parameter int MODE     = 0,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   in_valid,
    input  logic [CHANNELS*N-1:0] in_data,
    output logic [CHANNELS-1:0]   in_ready,
    output logic                  out_valid,
    output logic [N-1:0]          out_data,
    output logic [SEL_W-1:0]      out_select,
    input  logic                  out_ready
);

    localparam logic [SEL_W:0]   CH_EXT  = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS-1);

    logic             r_valid;
    logic [N-1:0]     r_data;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_ptr;

    logic [N-1:0]     w_ch [CHANNELS];
    logic             w_load_ok;
    logic             w_found;
    logic             w_xfer;
    logic [SEL_W-1:0] w_sel;
    logic [SEL_W:0]   w_idx;

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_ch
            assign w_ch[g] = in_data[g*N +: N];
        end
    endgenerate

    // Scan channels in priority order starting at the pointer; the extra
    // index bit lets ptr+k wrap correctly for non-power-of-two counts.
    always_comb begin
        w_load_ok = !r_valid || out_ready;
        w_found   = 1'b0;
        w_sel     = '0;
        w_idx     = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (MODE == 1)
                w_idx = (SEL_W+1)'(k);
            else
                w_idx = {1'b0, r_ptr} + (SEL_W+1)'(k);
            if (w_idx >= CH_EXT)
                w_idx = w_idx - CH_EXT;
            if (!w_found && in_valid[w_idx[SEL_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[SEL_W-1:0];
            end
        end
    end

    assign w_xfer = rst && w_found && w_load_ok;

    always_comb begin
        in_ready        = '0;
        in_ready[w_sel] = w_xfer;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_ch[w_sel];
            r_sel   <= w_sel;
            if (MODE == 0)
                r_ptr <= (w_sel == LAST_CH) ? '0 : w_sel + SEL_W'(1);
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid  = r_valid;
    assign out_data   = r_data;
    assign out_select = r_sel;

endmodule

// File: tb/tb_rr_mux.sv
// Bench for rr_mux: 4-ch round-robin with scoreboard, 4-ch fixed priority,
// and 5-ch round-robin for pointer wrap.
module tb_rr_mux;

    logic clk;
    logic rst;

    logic [3:0]  a_iv, a_ir;
    logic [31:0] a_id;
    logic        a_ov, a_ordy;
    logic [7:0]  a_od;
    logic [1:0]  a_os;

    logic [3:0]  b_iv, b_ir;
    logic [31:0] b_id;
    logic        b_ov, b_ordy;
    logic [7:0]  b_od;
    logic [1:0]  b_os;

    logic [4:0]  c_iv, c_ir;
    logic [39:0] c_id;
    logic        c_ov, c_ordy;
    logic [7:0]  c_od;
    logic [2:0]  c_os;

    int n_chk  = 0;
    int n_fail = 0;

    // scoreboard for instance A: {select, data}
    logic [9:0] sb_q[$];
    int         m_ptr;
    logic       m_ov;

    rr_mux #(.N(8), .CHANNELS(4), .MODE(0)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
        .out_valid(a_ov), .out_data(a_od), .out_select(a_os), .out_ready(a_ordy));

    rr_mux #(.N(8), .CHANNELS(4), .MODE(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_data(b_id), .in_ready(b_ir),
        .out_valid(b_ov), .out_data(b_od), .out_select(b_os), .out_ready(b_ordy));

    rr_mux #(.N(8), .CHANNELS(5), .MODE(0)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_iv), .in_data(c_id), .in_ready(c_ir),
        .out_valid(c_ov), .out_data(c_od), .out_select(c_os), .out_ready(c_ordy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // One cycle on instance A: drive, check outputs against the scoreboard,
    // check the grant against the reference arbiter, then record any transfer.
    task automatic a_step(input logic [3:0] iv, input logic ordy);
        int g;
        logic [9:0] head;
        @(negedge clk);
        a_iv   = iv;
        a_ordy = ordy;
        #1;
        chk("a_out_valid", a_ov, m_ov);
        if (m_ov) begin
            head = sb_q[0];
            chk("a_out_data", a_od, head[7:0]);
            chk("a_out_select", a_os, head[9:8]);
            if (ordy) void'(sb_q.pop_front());
        end
        g = -1;
        if (!m_ov || ordy) begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (g < 0 && iv[c]) g = c;
            end
        end
        chk("a_in_ready", a_ir, (g < 0) ? 64'd0 : (64'd1 << g));
        if (g >= 0) begin
            sb_q.push_back({g[1:0], a_id[g*8 +: 8]});
            m_ptr = (g + 1) % 4;
            m_ov  = 1'b1;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0;
        a_iv = 4'hF; a_ordy = 1'b1; a_id = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        b_iv = 4'hF; b_ordy = 1'b1; b_id = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
        c_iv = 5'h1F; c_ordy = 1'b1; c_id = {8'hC4, 8'hC3, 8'hC2, 8'hC1, 8'hC0};
        m_ptr = 0; m_ov = 1'b0;

        // reset held two cycles with requests asserted
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk("rst_a_in_ready", a_ir, 0);
            chk("rst_b_in_ready", b_ir, 0);
            chk("rst_c_in_ready", c_ir, 0);
        end
        chk("rst_out_valid", a_ov, 0);
        chk("rst_out_data", a_od, 0);
        chk("rst_out_select", a_os, 0);
        chk("rst_ptr", u_a.r_ptr, 0);
        a_iv = '0; b_iv = '0; c_iv = '0;
        rst = 1'b1;

        // round-robin: all channels requesting, 8 transfers
        for (int i = 0; i < 8; i++) a_step(4'hF, 1'b1);

        // backpressure: load channel 2, stall three cycles, then release
        a_id[23:16] = 8'h5C;
        a_step(4'b0100, 1'b1);
        for (int i = 0; i < 3; i++) a_step(4'hF, 1'b0);
        a_step(4'hF, 1'b1);
        chk("bp_grant_ch3", a_ir, 4'b1000);
        a_step(4'h0, 1'b1);

        // reset while holding a word
        a_id[7:0] = 8'h77;
        a_step(4'b0001, 1'b1);
        a_step(4'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0; a_iv = 4'hF; a_ordy = 1'b0;
        #1;
        chk("midrst_in_ready", a_ir, 0);
        m_ptr = 0; m_ov = 1'b0; sb_q.delete();
        @(negedge clk);
        rst = 1'b1; a_iv = 4'h0;
        #1;
        chk("midrst_out_valid", a_ov, 0);
        chk("midrst_out_data", a_od, 0);
        chk("midrst_ptr", u_a.r_ptr, 0);
        a_step(4'hF, 1'b1);
        chk("midrst_grant_ch0", a_ir, 4'b0001);
        a_step(4'h0, 1'b1);

        // fixed priority: channels 1 and 3 requesting, 1 always wins
        @(negedge clk);
        b_iv = 4'b1010; b_ordy = 1'b1;
        #1;
        chk("fp_in_ready", b_ir, 4'b0010);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("fp_in_ready", b_ir, 4'b0010);
            chk("fp_out_valid", b_ov, 1);
            chk("fp_out_select", b_os, 1);
            chk("fp_out_data", b_od, 8'hB1);
            chk("fp_ptr", u_b.r_ptr, 0);
        end
        b_iv = 4'h0;

        // five channels: pointer wraps from channel 4 back to 0
        @(negedge clk);
        c_iv = 5'b10000;
        #1;
        chk("np_grant_ch4", c_ir, 5'b10000);
        chk("np_ptr_init", u_c.r_ptr, 0);
        @(negedge clk);
        c_iv = 5'b00001;
        #1;
        chk("np_select_4", c_os, 4);
        chk("np_data_4", c_od, 8'hC4);
        chk("np_ptr_wrap", u_c.r_ptr, 0);
        chk("np_grant_ch0", c_ir, 5'b00001);
        @(negedge clk);
        c_iv = 5'b00000;
        #1;
        chk("np_select_0", c_os, 0);
        chk("np_data_0", c_od, 8'hC0);
        chk("np_ptr_1", u_c.r_ptr, 1);
        chk("np_out_valid", c_ov, 1);
        @(negedge clk); #1;
        chk("np_drained", c_ov, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
